hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 152 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use stall, branch flush and overflow exception control
// for a 5-stage pipeline, with a saturating stall-cycle counter.
module hazard_ctrl #(
  parameter int DS         = 4,
  parameter int LOAD_LAT   = 1,
  parameter int BR_PENALTY = 1,
  parameter int CNT_W      = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [DS-1:0]    IF_ID_OP1,
  input  logic [DS-1:0]    IF_ID_OP2,
  input  logic             IF_ID_USE2,
  input  logic [DS-1:0]    ID_EX_RD,
  input  logic             ID_EX_MEM_READ,
  input  logic             BRANCH_JUMP_FLAG,
  input  logic             OVER_FLOW,
  output logic             PC_WRITE,
  output logic             IF_ID_WRITE,
  output logic             IF_ID_FLASH,
  output logic             ID_HAZARD_FLASH,
  output logic             EX_FLASH,
  output logic             EXC_PC_SEL,
  output logic [1:0]       HAZ_STATE,
  output logic [CNT_W-1:0] STALL_CNT
);

  localparam int RW = $clog2(5);

  localparam logic [RW-1:0] LD_REM =
    (LOAD_LAT > 1) ? RW'(LOAD_LAT - 2) : '0;
  localparam logic [RW-1:0] BR_REM =
    (BR_PENALTY > 1) ? RW'(BR_PENALTY - 2) : '0;
  localparam logic [RW-1:0] REM_ONE = RW'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_STALL = 2'd1,
    S_FLUSH = 2'd2,
    S_EXC   = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [RW-1:0]   rem_q, rem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            lu;

  assign lu = ID_EX_MEM_READ && (ID_EX_RD != '0) &&
              ((ID_EX_RD == IF_ID_OP1) ||
               (IF_ID_USE2 && (ID_EX_RD == IF_ID_OP2)));

  // State and remaining-cycle register; reset wins over any event
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  // Next state: overflow, then branch, then hold, then load-use
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    if (OVER_FLOW) begin
      state_d = S_EXC;
      rem_d   = '0;
    end else if (BRANCH_JUMP_FLAG) begin
      state_d = (BR_PENALTY > 1) ? S_FLUSH : S_IDLE;
      rem_d   = BR_REM;
    end else begin
      unique case (state_q)
        S_STALL, S_FLUSH: begin
          if (rem_q == '0) state_d = S_IDLE;
          else             rem_d   = rem_q - REM_ONE;
        end
        S_EXC: state_d = S_IDLE;
        S_IDLE: begin
          if (lu) begin
            state_d = (LOAD_LAT > 1) ? S_STALL : S_IDLE;
            rem_d   = LD_REM;
          end
        end
      endcase
    end
  end

  // Pipeline controls, same priority order as the next-state logic
  always_comb begin
    PC_WRITE        = 1'b1;
    IF_ID_WRITE     = 1'b1;
    IF_ID_FLASH     = 1'b0;
    ID_HAZARD_FLASH = 1'b0;
    EX_FLASH        = 1'b0;
    EXC_PC_SEL      = 1'b0;
    if (!RST_N) begin
      PC_WRITE        = 1'b0;
      IF_ID_WRITE     = 1'b0;
      IF_ID_FLASH     = 1'b1;
      ID_HAZARD_FLASH = 1'b1;
      EX_FLASH        = 1'b1;
    end else if (OVER_FLOW) begin
      IF_ID_FLASH     = 1'b1;
      ID_HAZARD_FLASH = 1'b1;
      EX_FLASH        = 1'b1;
      EXC_PC_SEL      = 1'b1;
    end else if (BRANCH_JUMP_FLAG) begin
      IF_ID_WRITE     = 1'b0;
      IF_ID_FLASH     = 1'b1;
      ID_HAZARD_FLASH = 1'b1;
    end else begin
      unique case (state_q)
        S_STALL: begin
          PC_WRITE        = 1'b0;
          IF_ID_WRITE     = 1'b0;
          ID_HAZARD_FLASH = 1'b1;
        end
        S_FLUSH, S_EXC: begin
          IF_ID_WRITE     = 1'b0;
          IF_ID_FLASH     = 1'b1;
          ID_HAZARD_FLASH = 1'b1;
        end
        S_IDLE: begin
          if (lu) begin
            PC_WRITE        = 1'b0;
            IF_ID_WRITE     = 1'b0;
            ID_HAZARD_FLASH = 1'b1;
          end
        end
      endcase
    end
  end

  // Saturating count of cycles in which the PC is held
  always_comb begin
    cnt_d = cnt_q;
    if (!PC_WRITE && (cnt_q != '1)) cnt_d = cnt_q + CNT_ONE;
  end

  // Stall counter register
  always_ff @(posedge CLK) begin
    if (!RST_N) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign HAZ_STATE = state_q;
  assign STALL_CNT = cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: two instances share stimulus,
// A (LOAD_LAT=3, BR_PENALTY=2) and B (LOAD_LAT=4, BR_PENALTY=1, CNT_W=4).
module tb_hazard_ctrl;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic [3:0] OP1, OP2, RD;
  logic       USE2, MR, BR, OF;

  logic pcw_a, ifw_a, iff_a, idf_a, exf_a, exc_a;
  logic pcw_b, ifw_b, iff_b, idf_b, exf_b, exc_b;
  logic [1:0]  haz_a, haz_b;
  logic [15:0] cnt_a;
  logic [3:0]  cnt_b;
  logic [5:0]  ctl_a, ctl_b;

  int pass = 0;
  int total = 0;

  // {PC_WRITE, IF_ID_WRITE, IF_ID_FLASH, ID_HAZARD_FLASH, EX_FLASH, EXC_PC_SEL}
  localparam logic [5:0] NORM = 6'b110000;
  localparam logic [5:0] STLC = 6'b000100;
  localparam logic [5:0] BRC  = 6'b101100;
  localparam logic [5:0] OVC  = 6'b111111;
  localparam logic [5:0] RSTC = 6'b001110;
  localparam logic [5:0] EXM  = 6'b101111;

  assign ctl_a = {pcw_a, ifw_a, iff_a, idf_a, exf_a, exc_a};
  assign ctl_b = {pcw_b, ifw_b, iff_b, idf_b, exf_b, exc_b};

  always #5 CLK = ~CLK;

  hazard_ctrl #(.DS(4), .LOAD_LAT(3), .BR_PENALTY(2), .CNT_W(16)) u_a (
    .CLK(CLK), .RST_N(RST_N),
    .IF_ID_OP1(OP1), .IF_ID_OP2(OP2), .IF_ID_USE2(USE2),
    .ID_EX_RD(RD), .ID_EX_MEM_READ(MR),
    .BRANCH_JUMP_FLAG(BR), .OVER_FLOW(OF),
    .PC_WRITE(pcw_a), .IF_ID_WRITE(ifw_a), .IF_ID_FLASH(iff_a),
    .ID_HAZARD_FLASH(idf_a), .EX_FLASH(exf_a), .EXC_PC_SEL(exc_a),
    .HAZ_STATE(haz_a), .STALL_CNT(cnt_a)
  );

  hazard_ctrl #(.DS(4), .LOAD_LAT(4), .BR_PENALTY(1), .CNT_W(4)) u_b (
    .CLK(CLK), .RST_N(RST_N),
    .IF_ID_OP1(OP1), .IF_ID_OP2(OP2), .IF_ID_USE2(USE2),
    .ID_EX_RD(RD), .ID_EX_MEM_READ(MR),
    .BRANCH_JUMP_FLAG(BR), .OVER_FLOW(OF),
    .PC_WRITE(pcw_b), .IF_ID_WRITE(ifw_b), .IF_ID_FLASH(iff_b),
    .ID_HAZARD_FLASH(idf_b), .EX_FLASH(exf_b), .EXC_PC_SEL(exc_b),
    .HAZ_STATE(haz_b), .STALL_CNT(cnt_b)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clr();
    OP1 = 4'd0; OP2 = 4'd0; RD = 4'd0;
    USE2 = 1'b0; MR = 1'b0; BR = 1'b0; OF = 1'b0;
  endtask

  task automatic do_reset();
    clr();
    RST_N = 1'b0;
    tick();
    RST_N = 1'b1;
  endtask

  task automatic set_lu();
    MR = 1'b1; RD = 4'd5; OP1 = 4'd5;
  endtask

  task automatic test_reset();
    clr();
    RST_N = 1'b0;
    OF = 1'b1;
    #1;
    total++; if (ctl_a !== RSTC) $display("FAIL rst_ctl got %b want %b", ctl_a, RSTC); else pass++;
    tick();
    total++; if (haz_a !== 2'd0) $display("FAIL rst_haz got %0d want 0", haz_a); else pass++;
    total++; if (cnt_a !== 16'd0) $display("FAIL rst_cnt got %0d want 0", cnt_a); else pass++;
    OF = 1'b0;
    RST_N = 1'b1;
    #1;
    total++; if (ctl_a !== NORM) $display("FAIL post_rst_ctl got %b want %b", ctl_a, NORM); else pass++;
    tick();
    total++; if (haz_a !== 2'd0) $display("FAIL post_rst_haz got %0d want 0", haz_a); else pass++;
  endtask

  task automatic test_load_use();
    do_reset();
    set_lu();
    #1;
    total++; if (ctl_a !== STLC) $display("FAIL lu_c1_ctl got %b want %b", ctl_a, STLC); else pass++;
    tick();
    clr();
    #1;
    total++; if (haz_a !== 2'd1) $display("FAIL lu_c2_haz got %0d want 1", haz_a); else pass++;
    total++; if (ctl_a !== STLC) $display("FAIL lu_c2_ctl got %b want %b", ctl_a, STLC); else pass++;
    tick();
    total++; if (haz_a !== 2'd1) $display("FAIL lu_c3_haz got %0d want 1", haz_a); else pass++;
    total++; if (ctl_a !== STLC) $display("FAIL lu_c3_ctl got %b want %b", ctl_a, STLC); else pass++;
    tick();
    total++; if (haz_a !== 2'd0) $display("FAIL lu_end_haz got %0d want 0", haz_a); else pass++;
    total++; if (ctl_a !== NORM) $display("FAIL lu_end_ctl got %b want %b", ctl_a, NORM); else pass++;
    total++; if (cnt_a !== 16'd3) $display("FAIL lu_cnt got %0d want 3", cnt_a); else pass++;
  endtask

  task automatic test_no_hazard();
    do_reset();
    MR = 1'b1; RD = 4'd0; OP1 = 4'd0;
    #1;
    total++; if (ctl_a !== NORM) $display("FAIL r0_ctl got %b want %b", ctl_a, NORM); else pass++;
    tick();
    RD = 4'd7; OP2 = 4'd7; OP1 = 4'd3; USE2 = 1'b0;
    #1;
    total++; if (ctl_a !== NORM) $display("FAIL nouse2_ctl got %b want %b", ctl_a, NORM); else pass++;
    tick();
    total++; if (cnt_a !== 16'd0) $display("FAIL nohaz_cnt got %0d want 0", cnt_a); else pass++;
    USE2 = 1'b1;
    #1;
    total++; if (ctl_a !== STLC) $display("FAIL use2_ctl got %b want %b", ctl_a, STLC); else pass++;
    clr();
  endtask

  task automatic test_branch_lu();
    do_reset();
    set_lu();
    BR = 1'b1;
    #1;
    total++; if (ctl_a !== BRC) $display("FAIL br_c1_ctl got %b want %b", ctl_a, BRC); else pass++;
    tick();
    clr();
    #1;
    total++; if (haz_a !== 2'd2) $display("FAIL br_c2_haz got %0d want 2", haz_a); else pass++;
    total++; if (ctl_a !== BRC) $display("FAIL br_c2_ctl got %b want %b", ctl_a, BRC); else pass++;
    total++; if (ctl_b !== NORM) $display("FAIL br1_c2_ctl got %b want %b", ctl_b, NORM); else pass++;
    tick();
    total++; if (ctl_a !== NORM) $display("FAIL br_end_ctl got %b want %b", ctl_a, NORM); else pass++;
    total++; if (cnt_a !== 16'd0) $display("FAIL br_cnt got %0d want 0", cnt_a); else pass++;
  endtask

  task automatic test_overflow_in_stall();
    do_reset();
    set_lu();
    #1;
    total++; if (ctl_b !== STLC) $display("FAIL ov_c1_ctl got %b want %b", ctl_b, STLC); else pass++;
    tick();
    clr();
    OF = 1'b1;
    #1;
    total++; if (haz_b !== 2'd1) $display("FAIL ov_c2_haz got %0d want 1", haz_b); else pass++;
    total++; if (ctl_b !== OVC) $display("FAIL ov_c2_ctl got %b want %b", ctl_b, OVC); else pass++;
    tick();
    OF = 1'b0;
    #1;
    total++; if (haz_b !== 2'd3) $display("FAIL exc_haz got %0d want 3", haz_b); else pass++;
    total++; if ((ctl_b & EXM) !== BRC) $display("FAIL exc_ctl got %b want %b", ctl_b & EXM, BRC); else pass++;
    tick();
    total++; if (haz_b !== 2'd0) $display("FAIL exc_end_haz got %0d want 0", haz_b); else pass++;
    total++; if (ctl_b !== NORM) $display("FAIL exc_end_ctl got %b want %b", ctl_b, NORM); else pass++;
    total++; if (cnt_b !== 4'd1) $display("FAIL ov_cnt got %0d want 1", cnt_b); else pass++;
  endtask

  task automatic test_reset_flush();
    do_reset();
    set_lu();
    tick();
    clr();
    tick();
    tick();
    BR = 1'b1;
    tick();
    BR = 1'b0;
    #1;
    total++; if (haz_a !== 2'd2) $display("FAIL rf_pre_haz got %0d want 2", haz_a); else pass++;
    total++; if (cnt_a !== 16'd3) $display("FAIL rf_pre_cnt got %0d want 3", cnt_a); else pass++;
    RST_N = 1'b0;
    #1;
    total++; if (ctl_a !== RSTC) $display("FAIL rf_ctl got %b want %b", ctl_a, RSTC); else pass++;
    tick();
    RST_N = 1'b1;
    total++; if (haz_a !== 2'd0) $display("FAIL rf_haz got %0d want 0", haz_a); else pass++;
    total++; if (cnt_a !== 16'd0) $display("FAIL rf_cnt got %0d want 0", cnt_a); else pass++;
  endtask

  task automatic test_saturate();
    do_reset();
    set_lu();
    for (int i = 0; i < 14; i++) tick();
    total++; if (cnt_b !== 4'd14) $display("FAIL sat14_cnt got %0d want 14", cnt_b); else pass++;
    for (int i = 0; i < 6; i++) tick();
    total++; if (cnt_b !== 4'd15) $display("FAIL sat_cnt got %0d want 15", cnt_b); else pass++;
    total++; if (ctl_b !== STLC) $display("FAIL sat_ctl got %b want %b", ctl_b, STLC); else pass++;
    clr();
  endtask

  initial begin
    clr();
    RST_N = 1'b0;
    test_reset();
    test_load_use();
    test_no_hazard();
    test_branch_lu();
    test_overflow_in_stall();
    test_reset_flush();
    test_saturate();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
